srec_stream_loader: RTL and testbench
=====================================

// Module: srec_stream_loader
// PURPOSE
//  Synthesizable Motorola S-record parser. Consumes an ASCII byte stream (UART/JTAG
//  mailbox), validates each record and emits aligned, byte-strobed memory write beats.
//  Reports the S7/S8/S9 entry point. Sits between debug/boot char source and L2 write port.
// PARAMETERS
//  DATA_WIDTH      64  write beat width in bits; 32/64/128; LANES = DATA_WIDTH/8
//  ADDR_WIDTH      32  write address width; record addresses zero-extended or truncated
//  MAX_DATA_BYTES  64  payload buffer depth in bytes; longer records raise ERR_LEN
//  CHECK_COUNT     1   1: S5/S6 counts compared against accepted data-record count
// PORTS
//  clk_i          in   1          clock
//  rst_ni         in   1          asynchronous active-low reset
//  clear_i        in   1          sync clear: errors, done, counters -> idle
//  char_valid_i   in   1          ASCII char valid
//  char_ready_o   out  1          char accepted when valid&ready
//  char_i         in   8          ASCII character
//  wr_valid_o     out  1          write beat valid
//  wr_ready_i     in   1          write beat accepted
//  wr_addr_o      out  ADDR_WIDTH beat address, aligned to LANES
//  wr_data_o      out  DATA_WIDTH beat data, lane i = byte at wr_addr_o+i
//  wr_be_o        out  LANES      byte enables
//  rec_cnt_o      out  16         accepted S1/S2/S3 records (saturating)
//  entry_o        out  32         entry address from termination record
//  done_o         out  1          termination record accepted (sticky)
//  err_o          out  1          sticky error
//  err_code_o     out  3          0 none,1 BAD_HEX,2 CHECKSUM,3 LEN,4 TYPE,5 TRUNC,6 COUNT
// BEHAVIOUR
//  Reset: all outputs 0; char_ready_o=1 after reset; FSM in IDLE.
//  FSM: IDLE -> TYPE -> CNT_H/CNT_L -> BODY_H/BODY_L (addr, data, cksum) -> CHECK
//   -> DRAIN (data recs) | DONE (S7-9) | IDLE (S0/S5/S6); any fault -> ERR.
//  IDLE: 'S' starts record; CR, LF, space, tab ignored; other chars ignored.
//  TYPE: '0'-'3','5'-'9' accepted; '4' or non-digit -> ERR_TYPE. Addr bytes: 2 for S0/1/5/9, 3 for S2/6/8, 4 for S3/7.
//  Hex: 0-9, A-F, a-f; high nybble first. Whitespace or non-hex in record -> ERR_BAD_HEX.
//   'S' in record -> ERR_TRUNC; partial record dropped, no beat emitted.
//  Count < addr_bytes+1, or payload > MAX_DATA_BYTES -> ERR_LEN, checked at CNT_L.
//  Checksum: 8-bit sum of count, address, data and checksum bytes must equal 8'hFF. Else ERR_CHECKSUM.
//   Checked in CHECK, 1 cycle after last nybble. Nothing is written before the check passes.
//  DRAIN: char_ready_o=0. Payload walked from lane = addr%LANES. Beat issued when lane wraps or last byte.
//   wr_be_o marks only written lanes; unwritten wr_data_o lanes = 0. Address wraps mod 2^ADDR_WIDTH.
//   Beat increments to aligned addr+LANES. Zero-length data record: no beat, still counted.
//   wr_valid_o/addr/data/be stay stable until wr_ready_i. First beat 1 cycle after CHECK.
//   One beat per cycle under continuous ready. Return to IDLE after last handshake.
//  S5/S6 with CHECK_COUNT=1: value != rec_cnt_o[15:0] (S6 zero-ext) -> ERR_COUNT.
//  S7/8/9: entry_o = address (zero-ext); done_o=1. DONE keeps char_ready_o=1 and discards all chars.
//  ERR: err_o=1, err_code_o = first error, held. char_ready_o=1, chars discarded.
//  clear_i: any state -> IDLE. Clears err, done, entry_o, rec_cnt_o.
//   In DRAIN, an unaccepted beat is dropped: wr_valid_o deasserts next cycle. Priority over char handshake.
//  Async reset mid-DRAIN: wr_valid_o drops immediately.
// STRUCTURE
//  srec_loader_pkg: srec_state_e, srec_err_e, srec_addr_bytes(type) function, hex2nyb() function.
//  Sub-module srec_beat_packer: payload buffer (MAX_DATA_BYTES regs), base addr, length in;
//   emits aligned beats with valid/ready. Parser FSM, checksum and counters live in top.
// TESTING
//  1 DW=64, "S30900001000DEADBEEFAE\n" -> 1 beat addr 0x1000, data[31:0]=0xEFBEADDE, be=0x0F.
//    rec_cnt_o=1.
//  2 "S30900001006DEADBEEFA8" -> beat 0x1000 be=0xC0 data[63:48]=0xADDE.
//    Then 0x1008 be=0x03 data[15:0]=0xEFBE.
//  3 Case 1 with last byte AF -> err_o=1, err_code_o=2, no wr_valid_o.
//    Later records ignored until clear_i.
//  4 Case 1 then "S5030001FB" then "S70500002000DA" -> no error; entry_o=0x2000, done_o=1.
//    Trailing chars ignored.
//  5 wr_ready_i low 10 cycles in case 2 -> beat 1 held stable, char_ready_o=0 throughout.
//    Both beats eventually accepted in order.
//  6 "S309000010" then 'S' -> err_code_o=5. clear_i then case 1 -> correct single beat.
//    Also: rst_ni low mid-DRAIN -> all outputs 0.

Source files
------------

// File: rtl/srec_loader_pkg.sv
// Shared types and helpers for the S-record stream loader: parser states,
// error codes, address-field sizing and ASCII hex decoding.
package srec_loader_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_TYPE,
        S_CNT_H,
        S_CNT_L,
        S_BODY_H,
        S_BODY_L,
        S_CHECK,
        S_DRAIN,
        S_DONE,
        S_ERR
    } srec_state_e;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_BAD_HEX  = 3'd1,
        ERR_CHECKSUM = 3'd2,
        ERR_LEN      = 3'd3,
        ERR_TYPE     = 3'd4,
        ERR_TRUNC    = 3'd5,
        ERR_COUNT    = 3'd6
    } srec_err_e;

    localparam logic [7:0] CH_S = 8'h53;

    function automatic logic [2:0] srec_addr_bytes(input logic [3:0] typ);
        case (typ)
            4'd2, 4'd6, 4'd8: return 3'd3;
            4'd3, 4'd7:       return 3'd4;
            default:          return 3'd2;
        endcase
    endfunction

    // Bit 4 flags a legal hex digit, bits 3:0 carry its value.
    function automatic logic [4:0] hex2nyb(input logic [7:0] c);
        logic [4:0] r;
        r = 5'd0;
        if (c >= 8'h30 && c <= 8'h39)
            r = {1'b1, c[3:0]};
        else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
            r = {1'b1, c[3:0] + 4'd9};
        return r;
    endfunction

endpackage

// File: rtl/srec_stream_loader_if.sv
// Character-in / write-beat-out bus of the S-record loader. Signal suffixes
// are relative to the loader, which is the slave side.
interface srec_stream_loader_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32
);
    localparam int LANES = DATA_WIDTH / 8;

    logic                  char_valid_i;
    logic                  char_ready_o;
    logic [7:0]            char_i;
    logic                  wr_valid_o;
    logic                  wr_ready_i;
    logic [ADDR_WIDTH-1:0] wr_addr_o;
    logic [DATA_WIDTH-1:0] wr_data_o;
    logic [LANES-1:0]      wr_be_o;

    modport master (
        output char_valid_i, char_i, wr_ready_i,
        input  char_ready_o, wr_valid_o, wr_addr_o, wr_data_o, wr_be_o
    );

    modport slave (
        input  char_valid_i, char_i, wr_ready_i,
        output char_ready_o, wr_valid_o, wr_addr_o, wr_data_o, wr_be_o
    );
endinterface

// File: rtl/srec_beat_packer.sv
// Holds a validated record payload and walks it out as lane-aligned,
// byte-strobed write beats; beat contents are combinational from the walk state.
module srec_beat_packer #(
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_WIDTH     = 32,
    parameter int MAX_DATA_BYTES = 64
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  flush,
    input  logic                                  load_en,
    input  logic [$clog2(MAX_DATA_BYTES)-1:0]     load_idx,
    input  logic [7:0]                            load_byte,
    input  logic                                  start,
    input  logic [ADDR_WIDTH-1:0]                 base,
    input  logic [7:0]                            len,
    output logic                                  busy,
    output logic                                  wr_valid,
    input  logic                                  wr_ready,
    output logic [ADDR_WIDTH-1:0]                 wr_addr,
    output logic [DATA_WIDTH/8-1:0][7:0]          wr_data,
    output logic [DATA_WIDTH/8-1:0]               wr_be
);
    localparam int LANES = DATA_WIDTH / 8;
    localparam int LW    = $clog2(LANES);
    localparam int IDX_W = $clog2(MAX_DATA_BYTES);

    logic [MAX_DATA_BYTES-1:0][7:0] pay_q;
    logic                           active_q;
    logic [7:0]                     idx_q, rem_q, take;
    logic [LW-1:0]                  lane_q;
    logic [ADDR_WIDTH-1:0]          addr_q;

    always_ff @(posedge clk) begin
        if (load_en) pay_q[load_idx] <= load_byte;
    end

    // Lane j carries payload byte idx + (j - start lane) while bytes remain.
    always_comb begin
        int off;
        int k;
        off     = 0;
        k       = 0;
        wr_data = '0;
        wr_be   = '0;
        take    = 8'd0;
        for (int j = 0; j < LANES; j++) begin
            off = j - int'(lane_q);
            k   = int'(idx_q) + off;
            if (active_q && off >= 0 && off < int'(rem_q) && k < MAX_DATA_BYTES) begin
                wr_be[j]   = 1'b1;
                wr_data[j] = pay_q[IDX_W'(k)];
                take       = take + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            idx_q    <= 8'd0;
            rem_q    <= 8'd0;
            lane_q   <= '0;
            addr_q   <= '0;
        end else if (flush) begin
            active_q <= 1'b0;
        end else if (start) begin
            active_q <= (len != 8'd0);
            idx_q    <= 8'd0;
            rem_q    <= len;
            lane_q   <= base[LW-1:0];
            addr_q   <= {base[ADDR_WIDTH-1:LW], {LW{1'b0}}};
        end else if (active_q && wr_ready) begin
            idx_q    <= idx_q + take;
            rem_q    <= rem_q - take;
            lane_q   <= '0;
            addr_q   <= addr_q + ADDR_WIDTH'(LANES);
            active_q <= (rem_q != take);
        end
    end

    assign busy     = active_q;
    assign wr_valid = active_q;
    assign wr_addr  = addr_q;
endmodule

// File: rtl/srec_stream_loader.sv
// Motorola S-record parser: validates records from an ASCII stream and hands
// accepted payloads to the beat packer; tracks counts, entry point and errors.
module srec_stream_loader
    import srec_loader_pkg::*;
#(
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_WIDTH     = 32,
    parameter int MAX_DATA_BYTES = 64,
    parameter int CHECK_COUNT    = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    srec_stream_loader_if.slave  bus,
    output logic [15:0]          rec_cnt_o,
    output logic [31:0]          entry_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [2:0]           err_code_o
);
    localparam int LANES = DATA_WIDTH / 8;
    localparam int IDX_W = $clog2(MAX_DATA_BYTES);

    srec_state_e state_q, state_d;
    srec_err_e   err_d, err_code_q;

    logic [3:0]  typ_q, hi_q;
    logic [7:0]  cnt_q, bidx_q, sum_q, byte_v, plen;
    logic [31:0] addr_q;
    logic [15:0] rec_cnt_q;
    logic [31:0] entry_q;
    logic        done_q, err_q, rdy_en_q;
    logic [4:0]  nyb;
    logic [2:0]  ab;
    logic        fire, is_digit, len_bad, last_byte, is_data_byte;
    logic        start, load_en, rec_inc, done_set, pk_busy, pk_valid;
    logic [ADDR_WIDTH-1:0]   pk_addr;
    logic [LANES-1:0][7:0]   pk_data;
    logic [LANES-1:0]        pk_be;

    assign bus.char_ready_o = rdy_en_q && (state_q != S_CHECK) && (state_q != S_DRAIN);
    assign fire         = bus.char_valid_i && bus.char_ready_o;
    assign nyb          = hex2nyb(bus.char_i);
    assign byte_v       = {hi_q, nyb[3:0]};
    assign ab           = srec_addr_bytes(typ_q);
    assign is_digit     = (bus.char_i >= 8'h30) && (bus.char_i <= 8'h39);
    assign len_bad      = (int'(byte_v) < int'(ab) + 1) ||
                          (int'(byte_v) - int'(ab) - 1 > MAX_DATA_BYTES);
    assign last_byte    = (bidx_q == cnt_q - 8'd1);
    assign is_data_byte = (bidx_q >= 8'(ab)) && !last_byte;
    assign plen         = cnt_q - 8'(ab) - 8'd1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        err_d    = ERR_NONE;
        start    = 1'b0;
        load_en  = 1'b0;
        rec_inc  = 1'b0;
        done_set = 1'b0;
        if (clear_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (fire && bus.char_i == CH_S) state_d = S_TYPE;
                S_TYPE: if (fire) begin
                    if (is_digit && bus.char_i != 8'h34) state_d = S_CNT_H;
                    else                                  err_d   = ERR_TYPE;
                end
                S_CNT_H, S_CNT_L, S_BODY_H, S_BODY_L: if (fire) begin
                    if (bus.char_i == CH_S) err_d = ERR_TRUNC;
                    else if (!nyb[4])       err_d = ERR_BAD_HEX;
                    else begin
                        case (state_q)
                            S_CNT_H:  state_d = S_CNT_L;
                            S_CNT_L:  if (len_bad) err_d = ERR_LEN;
                                      else         state_d = S_BODY_H;
                            S_BODY_H: state_d = S_BODY_L;
                            default: begin
                                load_en = is_data_byte;
                                state_d = last_byte ? S_CHECK : S_BODY_H;
                            end
                        endcase
                    end
                end
                S_CHECK: begin
                    if (sum_q != 8'hFF) err_d = ERR_CHECKSUM;
                    else begin
                        case (typ_q)
                            4'd1, 4'd2, 4'd3: begin
                                rec_inc = 1'b1;
                                if (plen != 8'd0) begin
                                    start   = 1'b1;
                                    state_d = S_DRAIN;
                                end else state_d = S_IDLE;
                            end
                            4'd5, 4'd6: begin
                                if (CHECK_COUNT != 0 && addr_q != {16'h0, rec_cnt_q})
                                    err_d = ERR_COUNT;
                                else state_d = S_IDLE;
                            end
                            4'd7, 4'd8, 4'd9: begin
                                done_set = 1'b1;
                                state_d  = S_DONE;
                            end
                            default: state_d = S_IDLE;
                        endcase
                    end
                end
                S_DRAIN: if (!pk_busy) state_d = S_IDLE;
                default: ;
            endcase
            if (err_d != ERR_NONE) state_d = S_ERR;
        end
    end

    // Running sum starts with the count byte; address shifts in MSB first.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            typ_q      <= 4'd0;
            hi_q       <= 4'd0;
            cnt_q      <= 8'd0;
            bidx_q     <= 8'd0;
            sum_q      <= 8'd0;
            addr_q     <= 32'd0;
            rec_cnt_q  <= 16'd0;
            entry_q    <= 32'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            rdy_en_q   <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            if (clear_i) begin
                rec_cnt_q  <= 16'd0;
                entry_q    <= 32'd0;
                done_q     <= 1'b0;
                err_q      <= 1'b0;
                err_code_q <= ERR_NONE;
            end else begin
                if (fire) begin
                    case (state_q)
                        S_TYPE:            typ_q <= bus.char_i[3:0];
                        S_CNT_H, S_BODY_H: hi_q  <= nyb[3:0];
                        S_CNT_L: begin
                            cnt_q  <= byte_v;
                            sum_q  <= byte_v;
                            bidx_q <= 8'd0;
                            addr_q <= 32'd0;
                        end
                        S_BODY_L: begin
                            sum_q  <= sum_q + byte_v;
                            bidx_q <= bidx_q + 8'd1;
                            if (bidx_q < 8'(ab)) addr_q <= {addr_q[23:0], byte_v};
                        end
                        default: ;
                    endcase
                end
                if (rec_inc && rec_cnt_q != 16'hFFFF) rec_cnt_q <= rec_cnt_q + 16'd1;
                if (done_set) begin
                    done_q  <= 1'b1;
                    entry_q <= addr_q;
                end
                if (err_d != ERR_NONE) begin
                    err_q      <= 1'b1;
                    err_code_q <= err_d;
                end
            end
        end
    end

    srec_beat_packer #(
        .DATA_WIDTH     (DATA_WIDTH),
        .ADDR_WIDTH     (ADDR_WIDTH),
        .MAX_DATA_BYTES (MAX_DATA_BYTES)
    ) u_packer (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .flush     (clear_i),
        .load_en   (load_en),
        .load_idx  (IDX_W'(bidx_q - 8'(ab))),
        .load_byte (byte_v),
        .start     (start),
        .base      (ADDR_WIDTH'(addr_q)),
        .len       (plen),
        .busy      (pk_busy),
        .wr_valid  (pk_valid),
        .wr_ready  (bus.wr_ready_i),
        .wr_addr   (pk_addr),
        .wr_data   (pk_data),
        .wr_be     (pk_be)
    );

    assign bus.wr_valid_o = pk_valid;
    assign bus.wr_addr_o  = pk_addr;
    assign bus.wr_data_o  = pk_data;
    assign bus.wr_be_o    = pk_be;

    assign rec_cnt_o  = rec_cnt_q;
    assign entry_o    = entry_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign err_code_o = err_code_q;
endmodule

// File: tb/tb_srec_stream_loader.sv
// Directed-vector bench for the S-record loader: feeds hand-checked record
// strings and compares beats, counters, entry point and error codes.
module tb_srec_stream_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clear = 1'b0;
    logic [15:0] rec_cnt;
    logic [31:0] entry;
    logic        done, err;
    logic [2:0]  err_code;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] q_addr[$];
    logic [63:0] q_data[$];
    logic [7:0]  q_be[$];

    always #5 clk = ~clk;

    srec_stream_loader_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) bus();

    srec_stream_loader #(
        .DATA_WIDTH(64), .ADDR_WIDTH(32), .MAX_DATA_BYTES(64), .CHECK_COUNT(1)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .bus(bus),
        .rec_cnt_o(rec_cnt), .entry_o(entry), .done_o(done),
        .err_o(err), .err_code_o(err_code)
    );

    // Beats that will handshake on the coming rising edge
    always @(negedge clk) begin
        if (rst_n && bus.wr_valid_o && bus.wr_ready_i) begin
            q_addr.push_back(bus.wr_addr_o);
            q_data.push_back(bus.wr_data_o);
            q_be.push_back(bus.wr_be_o);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic send_char(input logic [7:0] c);
        int n;
        n = 0;
        @(negedge clk);
        bus.char_valid_i = 1'b1;
        bus.char_i       = c;
        while (!bus.char_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("char_timeout", 64'd1, 64'd0);
        @(negedge clk);
        bus.char_valid_i = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((bus.wr_valid_o || !bus.char_ready_o) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("idle_timeout", 64'd1, 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!bus.wr_valid_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("valid_timeout", 64'd1, 64'd0);
    endtask

    task automatic set_wr_ready(input logic v);
        @(posedge clk);
        #1 bus.wr_ready_i = v;
    endtask

    task automatic do_clear();
        @(negedge clk) clear = 1'b1;
        @(negedge clk) clear = 1'b0;
        q_addr.delete();
        q_data.delete();
        q_be.delete();
    endtask

    string      err_str [5] = '{"S3G", "S4", "S301", "S346", "S5030001FB"};
    logic [2:0] err_exp [5] = '{3'd1, 3'd4, 3'd3, 3'd3, 3'd6};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        int bad;
        logic [31:0] a0;
        logic [63:0] d0;
        logic [7:0]  b0;
        bus.char_valid_i = 1'b0;
        bus.char_i       = 8'h00;
        bus.wr_ready_i   = 1'b1;
        #2 rst_n = 1'b0;
        #3;
        chk("rst_char_ready", bus.char_ready_o, 0);
        chk("rst_wr_valid", bus.wr_valid_o, 0);
        chk("rst_err", {err, err_code}, 0);
        chk("rst_done_cnt", {done, rec_cnt, entry}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_ready", bus.char_ready_o, 1);

        // 1: single aligned 4-byte record
        send_str("S30900001000DEADBEEFAE\n");
        wait_idle();
        chk("t1_beats", q_addr.size(), 1);
        chk("t1_addr", q_addr[0], 32'h1000);
        chk("t1_data", q_data[0], 64'h00000000_EFBEADDE);
        chk("t1_be", q_be[0], 8'h0F);
        chk("t1_cnt", rec_cnt, 1);

        // 2: payload straddling a lane boundary
        q_addr.delete(); q_data.delete(); q_be.delete();
        send_str("S30900001006DEADBEEFA8");
        wait_idle();
        chk("t2_beats", q_addr.size(), 2);
        chk("t2_addr0", q_addr[0], 32'h1000);
        chk("t2_be0", q_be[0], 8'hC0);
        chk("t2_data0", q_data[0], 64'hADDE_0000_0000_0000);
        chk("t2_addr1", q_addr[1], 32'h1008);
        chk("t2_be1", q_be[1], 8'h03);
        chk("t2_data1", q_data[1], 64'h0000_0000_0000_EFBE);
        chk("t2_cnt", rec_cnt, 2);

        // 4: data, count, entry record, then trailing chars ignored
        do_clear();
        chk("clr_cnt", rec_cnt, 0);
        send_str("S30900001000DEADBEEFAE\n");
        wait_idle();
        send_str("S5030001FB\n");
        send_str("S70500002000DA\n");
        wait_idle();
        chk("t4_err", {err, err_code}, 0);
        chk("t4_entry", entry, 32'h2000);
        chk("t4_done", done, 1);
        q_addr.delete(); q_data.delete(); q_be.delete();
        send_str("S30900001000DEADBEEFAE");
        wait_idle();
        chk("t4_trail_beats", q_addr.size(), 0);
        chk("t4_trail_cnt", rec_cnt, 1);

        // 5: write back-pressure holds the first beat and blocks chars
        do_clear();
        chk("clr_done", {done, entry}, 0);
        set_wr_ready(1'b0);
        send_str("S30900001006DEADBEEFA8");
        wait_valid();
        a0 = bus.wr_addr_o; d0 = bus.wr_data_o; b0 = bus.wr_be_o;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.wr_addr_o !== a0 || bus.wr_data_o !== d0 || bus.wr_be_o !== b0 ||
                !bus.wr_valid_o || bus.char_ready_o) bad++;
        end
        chk("t5_stall_stable", bad, 0);
        set_wr_ready(1'b1);
        wait_idle();
        chk("t5_beats", q_addr.size(), 2);
        chk("t5_addr0", q_addr[0], 32'h1000);
        chk("t5_data0", q_data[0], 64'hADDE_0000_0000_0000);
        chk("t5_addr1", q_addr[1], 32'h1008);
        chk("t5_be1", q_be[1], 8'h03);

        // 3: bad checksum is sticky until clear
        do_clear();
        send_str("S30900001000DEADBEEFAF");
        wait_idle();
        chk("t3_err", {err, err_code}, {1'b1, 3'd2});
        chk("t3_beats", q_addr.size(), 0);
        send_str("S30900001000DEADBEEFAE");
        wait_idle();
        chk("t3_held", {err, err_code}, {1'b1, 3'd2});
        chk("t3_beats2", q_addr.size(), 0);
        chk("t3_cnt", rec_cnt, 0);

        // Error code table
        for (int i = 0; i < 5; i++) begin
            do_clear();
            send_str(err_str[i]);
            wait_idle();
            chk($sformatf("errtab_%0d", i), {err, err_code}, {1'b1, err_exp[i]});
        end

        // 6: truncated record, then recovery with lowercase hex
        do_clear();
        chk("t6_clr_err", {err, err_code}, 0);
        send_str("S309000010S");
        chk("t6_trunc", {err, err_code}, {1'b1, 3'd5});
        chk("t6_no_beat", q_addr.size(), 0);
        do_clear();
        send_str("S30900001000deadbeefae\n");
        wait_idle();
        chk("t6_beats", q_addr.size(), 1);
        chk("t6_addr", q_addr[0], 32'h1000);
        chk("t6_data", q_data[0], 64'h00000000_EFBEADDE);
        chk("t6_be", q_be[0], 8'h0F);

        // Async reset while a beat is pending
        set_wr_ready(1'b0);
        send_str("S30900001000DEADBEEFAE");
        wait_valid();
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("rstd_wr_valid", bus.wr_valid_o, 0);
        chk("rstd_outs", {bus.char_ready_o, done, err, err_code, rec_cnt, entry}, 0);
        @(negedge clk) rst_n = 1'b1;
        set_wr_ready(1'b1);
        q_addr.delete(); q_data.delete(); q_be.delete();
        send_str("S30900001006DEADBEEFA8");
        wait_idle();
        chk("post_rst_beats", q_addr.size(), 2);
        chk("post_rst_cnt", rec_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
